serial_adder_8bit: RTL and testbench
====================================

// Module: serial_adder_8bit
//
// PURPOSE
//   Bit-serial WIDTH-bit adder. It drives a single full_adder instance one bit
//   per clock and holds the carry in a flip-flop between bits. It is the
//   sequential stage built around the full_adder cell: it loads the operands,
//   feeds the cell LSB-first and collects {c_out,sum}. Its area is lower than
//   the ripple adder_8bit, at the cost of WIDTH cycles of latency.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits (WIDTH >= 1)
//
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous reset, active-low
//   start   in   1      request; sampled on clk edge only in IDLE or DONE
//   a       in   WIDTH  operand A; sampled only on the accepting edge
//   b       in   WIDTH  operand B; sampled only on the accepting edge
//   c_in    in   1      carry-in; sampled only on the accepting edge
//   busy    out  1      high while state == RUN
//   done    out  1      one-cycle pulse: sum/c_out just updated
//   sum     out  WIDTH  result, registered; holds last result
//   c_out   out  1      final carry, registered; holds last result
//
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-low (rst_n).
//   - Reset (rst_n=0, any time, including mid-operation):
//       state=IDLE; busy=0; done=0; sum=0; c_out=0;
//       shift regs, carry FF and bit counter cleared.
//     Any operation in flight is discarded with no done pulse.
//   - FSM states: IDLE, RUN, DONE.
//       IDLE: start=1 -> load a_sr<=a, b_sr<=b, carry<=c_in, cnt<=0; go RUN.
//       RUN:  each edge, full_adder(a_sr[0], b_sr[0], carry) produces s and co:
//             - carry<=co
//             - a_sr, b_sr shift right by one
//             - s is shifted into the MSB of res_sr
//             - cnt<=cnt+1
//             When cnt==WIDTH-1 on this edge: sum<=final res_sr,
//             c_out<=co, done<=1, go DONE.
//       DONE: done=1 for this single cycle.
//             start=1 -> accept (same load as IDLE), go RUN.
//             otherwise go IDLE.
//   - start is ignored in RUN. busy=1 tells upstream not to issue a request.
//   - Latency: start accepted on edge E0. Bits 0..WIDTH-1 are processed on
//     edges E1..E_WIDTH. done, sum and c_out update on E_WIDTH.
//     Back-to-back throughput is one result per WIDTH+1 cycles.
//   - sum and c_out change only on the completing edge (or on reset).
//     They are stable between results and are not cleared by start.
//   - Arithmetic: {c_out,sum} == a + b + c_in, modulo 2^(WIDTH+1).
//     Overflow is reported only through c_out; there is no wrap flag.
//   - cnt is wide enough for 0..WIDTH-1 and never wraps inside RUN.
//   - Changes to a, b or c_in after the accepting edge have no effect.
//
// TESTING
//   1. Assert rst_n=0 for 2 cycles
//      -> busy=0, done=0, sum=8'h00, c_out=0.
//   2. a=8'h0F, b=8'h01, c_in=0, start pulse
//      -> busy=1 for 8 cycles, done=1 for exactly one cycle 8 edges after
//         acceptance, sum=8'h10, c_out=0.
//   3. a=8'hFF, b=8'hFF, c_in=1
//      -> sum=8'hFF, c_out=1.
//      Then a=8'h00, b=8'h00, c_in=0
//      -> sum=8'h00, c_out=0.
//   4. Start with a=8'h12, b=8'h34. At cycle 3 pulse start with a=8'hAA, b=8'h55
//      -> second start ignored; result sum=8'h46, c_out=0.
//   5. Start with a=8'hF0, b=8'h10. Drop rst_n after 4 RUN edges
//      -> all outputs 0 immediately and no done pulse.
//      After release, start a=8'h01, b=8'h01 -> sum=8'h02.
//   6. Hold start=1 through DONE with a=8'h80, b=8'h80
//      -> new op accepted in the DONE cycle with no IDLE cycle in between;
//         prior sum holds until E_WIDTH; then sum=8'h00, c_out=1.
//   All scenarios: self-check every result against a+b+c_in
//   and run a 200-vector random sweep.

Source files
------------

// File: rtl/serial_adder_8bit_if.sv
// Request/result bundle for the bit-serial adder.
// The master drives the operands and start; the slave returns busy, done and the registered result.
interface serial_adder_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder_8bit.sv
// Bit-serial WIDTH-bit adder: a single full-adder cell is fed LSB-first,
// one bit per clock, and the carry is held in a flip-flop between bits.
// {c_out,sum} == a + b + c_in, and the result appears WIDTH edges after acceptance.

// One-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_8bit_if.slave   bus
);
  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             load;
  logic             step;
  logic             finish;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // Result shift register with the current sum bit entering at the MSB;
  // written as shift-then-overwrite so WIDTH=1 needs no special slicing.
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = fa_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand load, per-bit shift/carry update, and result capture on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
    end else if (load) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      carry <= bus.c_in;
      cnt   <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_co;
      res_sr <= res_next;
      cnt    <= cnt + 1'b1;
      if (finish) begin
        sum_r   <= res_next;
        c_out_r <= fa_co;
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_r;
  assign bus.c_out = c_out_r;
endmodule

// File: tb/tb_serial_adder_8bit.sv
// Bench for serial_adder_8bit: vector table, hand-written multi-cycle
// sequences and a random sweep, with a scoreboard checked on every done pulse.
module tb_serial_adder_8bit;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_8bit_if #(.WIDTH(W)) bus ();
  serial_adder_8bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   exp;
  } vec_t;

  int         n_cmp      = 0;
  int         n_bad      = 0;
  int         done_count = 0;
  logic [W:0] sb_q[$];
  logic [W:0] last_res   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request;
  // between pulses the result outputs must hold the last result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        done_count++;
        check("done_expected", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          logic [W:0] e;
          e = sb_q.pop_front();
          check("sb_result", {bus.c_out, bus.sum}, e);
          last_res = e;
        end
      end else begin
        check("result_hold", {bus.c_out, bus.sum}, last_res);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < W + 4 && !bus.done; i++) @(negedge clk);
    check("done_timeout", bus.done, 1);
  endtask

  // Issue one request, scramble the inputs after acceptance, then wait for completion.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W:0] exp);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.c_in = cin; bus.start = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.c_in = ~cin;
    wait_done();
    check("op_result", {bus.c_out, bus.sum}, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   saved;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 9'h010};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 9'h046};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vecs[5] = '{8'h7F, 8'h01, 1'b1, 9'h081};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 9'h100};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 9'h100};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.c_out, 0);
    rst_n = 1'b1;

    // Latency and busy/done timing for 0F+01
    @(negedge clk);
    bus.a = 8'h0F; bus.b = 8'h01; bus.c_in = 1'b0; bus.start = 1'b1;
    sb_q.push_back(9'h010);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("lat_busy", bus.busy, 1);
      check("lat_done_low", bus.done, 0);
      @(negedge clk);
    end
    check("lat_done", bus.done, 1);
    check("lat_busy_low", bus.busy, 0);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);

    // Vector table
    for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);

    // Start during RUN is ignored
    @(negedge clk);
    saved = done_count;
    bus.a = 8'h12; bus.b = 8'h34; bus.c_in = 1'b0; bus.start = 1'b1;
    sb_q.push_back(9'h046);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    check("ignore_result", {bus.c_out, bus.sum}, 9'h046);
    repeat (W + 3) @(negedge clk);
    check("ignore_one_done", done_count - saved, 1);

    // Reset mid-operation discards the request
    @(negedge clk);
    bus.a = 8'hF0; bus.b = 8'h10; bus.c_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    saved = done_count;
    rst_n = 1'b0;
    last_res = '0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_cout", bus.c_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    check("midrst_no_done", done_count - saved, 0);
    run_op(8'h01, 8'h01, 1'b0, 9'h002);

    // Back-to-back: start held through DONE is accepted with no IDLE cycle
    @(negedge clk);
    bus.a = 8'h80; bus.b = 8'h80; bus.c_in = 1'b0; bus.start = 1'b1;
    sb_q.push_back(9'h100);
    wait_done();
    check("b2b_first", {bus.c_out, bus.sum}, 9'h100);
    bus.a = 8'h01; bus.b = 8'h02;
    sb_q.push_back(9'h003);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_no_idle", bus.busy, 1);
    for (int i = 0; i < W - 1; i++) begin
      check("b2b_hold_prior", {bus.c_out, bus.sum}, 9'h100);
      @(negedge clk);
    end
    wait_done();
    check("b2b_second", {bus.c_out, bus.sum}, 9'h003);

    // Random sweep against the arithmetic model
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
